// File: rtl/ps2_host_tx_pkg.sv
// Shared constants for the PS/2 host transmitter: state encoding,
// default timing and frame geometry.
package ps2_host_tx_pkg;

  // Default timing at 24.39 MHz: 100 us inhibit, 20 ms transfer limit
  localparam int unsigned DEF_INHIBIT_CYCLES = 2440;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 487800;

  // A frame is start + 8 data + parity + stop. The start bit is placed
  // before the device clocks, so the remaining bits go out on falling edges.
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned SHIFT_BITS = FRAME_BITS - 1;
  localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_INHIBIT   = 3'd1;
  localparam state_t ST_START     = 3'd2;
  localparam state_t ST_SHIFT     = 3'd3;
  localparam state_t ST_ACK       = 3'd4;
  localparam state_t ST_WAIT_IDLE = 3'd5;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 line.
// All flops reset to 1, matching the idle (released) level of the bus.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Shift the raw line through the synchronizer and keep one cycle of history
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Requests the bus by inhibiting the
// clock, places the start bit, then shifts data/parity/stop on device
// falling edges, checks the device ACK and waits for the bus to go idle.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       tx_done_o,
  output logic       tx_error_o,
  output logic       busy_o
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Last inhibit count before START
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  // The counter starts at 0 in the cycle after START, so hitting this value
  // makes the error pulse appear exactly TIMEOUT_CYCLES cycles after START.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);
  // Falling edge that places the stop bit
  localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(SHIFT_BITS - 1);

  state_t                state_q,   state_d;
  logic [INH_W-1:0]      inh_q,     inh_d;
  logic [TMO_W-1:0]      tmo_q,     tmo_d;
  logic [BITCNT_W-1:0]   bit_q,     bit_d;
  logic [SHIFT_BITS-1:0] frame_q,   frame_d;
  logic                  clk_oe_q,  clk_oe_d;
  logic                  data_oe_q, data_oe_d;
  logic                  done_q,    done_d;
  logic                  err_q,     err_d;

  logic clk_level;
  logic clk_fall;
  logic data_level;
  logic unused_data_fall;
  logic timed;

  ps2_line_sync u_clk_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .line_i  (ps2_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .line_i  (ps2_data_i),
    .level_o (data_level),
    .fall_o  (unused_data_fall)
  );

  assign timed = (state_q == ST_SHIFT) || (state_q == ST_ACK) ||
                 (state_q == ST_WAIT_IDLE);

  // Next-state, counter and line-drive logic; timeout overrides everything
  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (timed) begin
      tmo_d = tmo_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid_i) begin
          frame_d  = {1'b1, odd_parity(tx_data_i), tx_data_i};
          inh_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          state_d   = ST_START;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      ST_START: begin
        tmo_d   = '0;
        bit_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[0];
          frame_d   = frame_q >> 1;
          bit_d     = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          if (!data_level) begin
            state_d = ST_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    if (timed && (tmo_q == TMO_LAST)) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b1;
      state_d   = ST_IDLE;
    end
  end

  // State, counters and registered outputs; reset releases both lines
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      inh_q     <= '0;
      tmo_q     <= '0;
      bit_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      tmo_q     <= tmo_d;
      bit_q     <= bit_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready_o    = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;
  assign tx_done_o     = done_q;
  assign tx_error_o    = err_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 2440, CLOCK cycles PS2_CLK is held low before a request (100 us at 24.39 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 487800, maximum CLOCK cycles from clock release to transfer completion (20 ms).
REQ-003 CLOCK  input  1  single system clock; all logic on rising edge.
REQ-004 RESET_N  input  1  reset; synchronous, active-low.
REQ-005 TX_DATA  input  8  byte to send to the PS/2 device.
REQ-006 TX_VALID  input  1  request; byte accepted on a cycle with TX_VALID=1 and TX_READY=1.
REQ-007 TX_READY  output  1  high only in IDLE.
REQ-008 PS2_CLK_IN  input  1  raw PS/2 clock line level (asynchronous).
REQ-009 PS2_DATA_IN  input  1  raw PS/2 data line level (asynchronous).
REQ-010 PS2_CLK_OE  output  1  1 = pull PS/2 clock low; 0 = release (open-drain).
REQ-011 PS2_DATA_OE  output  1  1 = pull PS/2 data low; 0 = release.
REQ-012 TX_DONE  output  1  one-cycle pulse: byte sent and acknowledged.
REQ-013 TX_ERROR  output  1  one-cycle pulse: timeout or missing ACK.
REQ-014 BUSY  output  1  high in every state except IDLE; the keyboard receiver ignores the line while BUSY=1.

Function
REQ-015 PS2_CLK_IN and PS2_DATA_IN SHALL each pass through a 2-flop synchronizer; falling edge = synced clock 1 in the previous cycle and 0 in the current cycle.
REQ-016 States SHALL be IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
REQ-017 IDLE: both OE=0; on accept, latch TX_DATA, compute odd parity (parity bit = XNOR-reduce of byte), go to INHIBIT.
REQ-018 INHIBIT: PS2_CLK_OE=1 for exactly INHIBIT_CYCLES cycles, then go to START.
REQ-019 START: PS2_DATA_OE=1 (start bit 0), PS2_CLK_OE=0, clear timeout counter and bit counter, go to SHIFT next cycle.
REQ-020 SHIFT: on each device falling edge, drive the next bit: data bits 0..7 LSB first, then parity, then stop (release); PS2_DATA_OE = NOT bit value.
REQ-021 After the 10th falling edge in SHIFT (stop bit placed, PS2_DATA_OE=0), go to ACK.
REQ-022 ACK: on the next falling edge, sample synced data; 0 goes to WAIT_IDLE, 1 pulses TX_ERROR and goes to IDLE.
REQ-023 WAIT_IDLE: when synced clock and data are both 1, pulse TX_DONE and go to IDLE.
REQ-024 Timeout counter SHALL run in SHIFT, ACK and WAIT_IDLE; on reaching TIMEOUT_CYCLES, release both lines, pulse TX_ERROR and go to IDLE in the same cycle.
REQ-025 TX_VALID while not in IDLE SHALL be ignored; no queueing.
REQ-026 TX_DONE and TX_ERROR SHALL never be asserted in the same cycle.
REQ-027 Both OE outputs SHALL be registered.

Reset
REQ-028 While RESET_N=0 at a rising edge: state IDLE; PS2_CLK_OE=0, PS2_DATA_OE=0, TX_DONE=0, TX_ERROR=0, BUSY=0, TX_READY=1; counters and shift register cleared; synchronizer flops set to 1.
REQ-029 Reset asserted mid-transfer SHALL release both lines on the next rising edge, with no TX_DONE or TX_ERROR pulse.

Structure
REQ-030 A shared package SHALL hold the state encoding, the default INHIBIT_CYCLES and TIMEOUT_CYCLES constants, and the bit count (11 frame bits).
REQ-031 The synchronizer and edge detector SHALL be one sub-module, ps2_line_sync, instantiated once per line.
REQ-032 Counter widths SHALL be derived from the parameters by clog2.

Verification
REQ-033 Send 0xED; device model clocks at 12.5 kHz and ACKs -> data line sequence 0,1,0,1,1,0,1,1,1,1(parity),1(stop); TX_DONE pulses once; BUSY falls in the same cycle.
REQ-034 Accept byte -> PS2_CLK_OE high for exactly 2440 cycles, then PS2_DATA_OE=1 and PS2_CLK_OE=0 in the next cycle.
REQ-035 Device never clocks after request -> TX_ERROR pulse exactly 487800 cycles after START; both OE=0; TX_READY=1.
REQ-036 Device holds data high at 11th falling edge (no ACK) -> TX_ERROR pulse, no TX_DONE.
REQ-037 RESET_N low during SHIFT bit 4 -> both OE=0 next edge; no pulses; next 0xF4 send completes normally.
REQ-038 TX_VALID held high through a transfer of 0x00 -> second byte accepted only after TX_DONE, TX_READY high one cycle.
